// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and helpers for the sprite ROM arbiter, its interface and the ROM wrapper.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package sprite_rom_arbiter_pkg;

    localparam int AW_DEF      = 15;
    localparam int DW_DEF      = 6;
    localparam int ROM_LAT_DEF = 1;
    localparam int MAX_REQ     = 4;

    function automatic logic [1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of requester-side and ROM-side signals around the sprite ROM arbiter.
interface sprite_rom_arbiter_if
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rom_en;
    logic [AW-1:0]         rom_addr;
    logic [DW-1:0]         rom_data;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [DW-1:0]         rd_data;

    modport master (
        output req, req_addr, rom_data,
        input  gnt, rom_en, rom_addr, rd_valid, rd_data
    );

    modport slave (
        input  req, req_addr, rom_data,
        output gnt, rom_en, rom_addr, rd_valid, rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int PW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[(int'(ptr) + i) % NUM_REQ]) begin
                winner[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among NUM_REQ drawers and routes data back by tag.
// Optional build macro: ARB_FIXED_PRIO_EN (lowest index always wins, ptr held at 0).
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF,
    localparam int PW     = $clog2(NUM_REQ)
) (
    input logic                vga_clk,
    input logic                reset,
    sprite_rom_arbiter_if.slave bus
);
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_next;
    logic [PW-1:0]      w_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [AW-1:0]      addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] tag [1:ROM_LAT];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*AW +: AW];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    assign w_idx = PW'(onehot_to_idx(MAX_REQ'(pick_oh)));

`ifdef ARB_FIXED_PRIO_EN
    assign ptr_next = '0;
`else
    assign ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
`endif

    // gnt is tag stage 0; tag[k] trails it by k cycles so rd_valid lands ROM_LAT+1 after the grant.
    // NOTE: sequential state uses <= only; the tag pipeline is reset so a reset drops in-flight reads.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            ptr          <= '0;
            bus.gnt      <= '0;
            bus.rom_en   <= 1'b0;
            bus.rom_addr <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
            for (int k = 1; k <= ROM_LAT; k++) tag[k] <= '0;
        end else begin
            bus.gnt    <= pick_oh;
            bus.rom_en <= pick_valid;
            if (pick_valid) begin
                bus.rom_addr <= addr_arr[w_idx];
                ptr          <= ptr_next;
            end
            tag[1] <= bus.gnt;
            for (int k = 2; k <= ROM_LAT; k++) tag[k] <= tag[k-1];
            bus.rd_valid <= tag[ROM_LAT];
            if (|tag[ROM_LAT]) bus.rd_data <= bus.rom_data;
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: ROM_LAT=1 instance plus a ROM_LAT=3 instance.
module tb_sprite_rom_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.NUM_REQ(2), .AW(15), .DW(6)) bus1 ();
    sprite_rom_arbiter_if #(.NUM_REQ(2), .AW(15), .DW(6)) bus3 ();

    sprite_rom_arbiter #(.NUM_REQ(2), .AW(15), .DW(6), .ROM_LAT(1)) u_dut (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus1)
    );

    sprite_rom_arbiter #(.NUM_REQ(2), .AW(15), .DW(6), .ROM_LAT(3)) u_dut3 (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus3)
    );

    // ROM contents: address 0x0123 holds 6'h2A.
    function automatic logic [5:0] rom_word(input logic [14:0] a);
        return a[5:0] ^ a[11:6] ^ {3'b000, a[14:12]} ^ 6'h0D;
    endfunction

    logic [5:0] rom1_q;
    logic [5:0] rom3_q [3];
    always @(posedge clk) rom1_q <= rom_word(bus1.rom_addr);
    always @(posedge clk) begin
        rom3_q[0] <= rom_word(bus3.rom_addr);
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign bus1.rom_data = rom1_q;
    assign bus3.rom_data = rom3_q[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus1.req = 2'b11;
        bus1.req_addr = {15'h0222, 15'h0111};
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus1.gnt, bus1.rom_en, bus1.rd_valid} !== 5'b0)
                $display("FAIL reset_hold[%0d]: gnt/en/rdv=%b want 00000", i,
                         {bus1.gnt, bus1.rom_en, bus1.rd_valid});
            else passes++;
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus1.gnt, bus1.rom_en, bus1.rom_addr} !== {2'b01, 1'b1, 15'h0111})
            $display("FAIL reset_first_grant: gnt=%b en=%b addr=%h want 01 1 0111",
                     bus1.gnt, bus1.rom_en, bus1.rom_addr);
        else passes++;
        bus1.req = 2'b00;
        tick();
        tick();
        checks++;
        if ({bus1.rd_valid, bus1.rd_data} !== {2'b01, rom_word(15'h0111)})
            $display("FAIL reset_first_return: rdv=%b data=%h want 01 %h",
                     bus1.rd_valid, bus1.rd_data, rom_word(15'h0111));
        else passes++;
        tick();
    endtask

    task automatic test_single();
        bus1.req = 2'b10;
        bus1.req_addr = {15'h0123, 15'h7777};
        tick();
        checks++;
        if ({bus1.gnt, bus1.rom_en, bus1.rom_addr, bus1.rd_valid} !== {2'b10, 1'b1, 15'h0123, 2'b00})
            $display("FAIL single_grant: gnt=%b en=%b addr=%h rdv=%b want 10 1 0123 00",
                     bus1.gnt, bus1.rom_en, bus1.rom_addr, bus1.rd_valid);
        else passes++;
        bus1.req = 2'b00;
        tick();
        checks++;
        if ({bus1.gnt, bus1.rom_en, bus1.rom_addr, bus1.rd_valid} !== {2'b00, 1'b0, 15'h0123, 2'b00})
            $display("FAIL single_idle: gnt=%b en=%b addr=%h rdv=%b want 00 0 0123 00",
                     bus1.gnt, bus1.rom_en, bus1.rom_addr, bus1.rd_valid);
        else passes++;
        tick();
        checks++;
        if ({bus1.rd_valid, bus1.rd_data} !== {2'b10, 6'h2A})
            $display("FAIL single_return: rdv=%b data=%h want 10 2a", bus1.rd_valid, bus1.rd_data);
        else passes++;
        tick();
        checks++;
        if ({bus1.rd_valid, bus1.rd_data} !== {2'b00, 6'h2A})
            $display("FAIL single_hold_data: rdv=%b data=%h want 00 2a", bus1.rd_valid, bus1.rd_data);
        else passes++;
    endtask

    task automatic test_contention();
        logic [1:0]  g_exp [6];
        logic [14:0] a_exp [6];
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                bus1.req = 2'b11;
                bus1.req_addr = {15'(15'h2000 + i), 15'(15'h1000 + i)};
            end else begin
                bus1.req = 2'b00;
            end
            tick();
            if (i < 6) begin
`ifdef ARB_FIXED_PRIO_EN
                g_exp[i] = 2'b01;
`else
                g_exp[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
                a_exp[i] = (g_exp[i] == 2'b01) ? 15'(15'h1000 + i) : 15'(15'h2000 + i);
                checks++;
                if ({bus1.gnt, bus1.rom_addr} !== {g_exp[i], a_exp[i]})
                    $display("FAIL contention_grant[%0d]: gnt=%b addr=%h want %b %h",
                             i, bus1.gnt, bus1.rom_addr, g_exp[i], a_exp[i]);
                else passes++;
            end
            if (i >= 2) begin
                checks++;
                if ({bus1.rd_valid, bus1.rd_data} !== {g_exp[i-2], rom_word(a_exp[i-2])})
                    $display("FAIL contention_return[%0d]: rdv=%b data=%h want %b %h",
                             i, bus1.rd_valid, bus1.rd_data, g_exp[i-2], rom_word(a_exp[i-2]));
                else passes++;
            end
        end
        tick();
    endtask

    task automatic test_single_hold();
        logic [1:0] rdv_exp;
        bus1.req_addr = {15'h0ABC, 15'h0DEF};
        for (int i = 0; i < 6; i++) begin
            bus1.req = (i < 3) ? 2'b10 : 2'b00;
            tick();
            rdv_exp = (i >= 2 && i < 5) ? 2'b10 : 2'b00;
            checks++;
            if ({bus1.gnt, bus1.rd_valid} !== {((i < 3) ? 2'b10 : 2'b00), rdv_exp})
                $display("FAIL single_hold[%0d]: gnt=%b rdv=%b want %b %b", i, bus1.gnt,
                         bus1.rd_valid, (i < 3) ? 2'b10 : 2'b00, rdv_exp);
            else passes++;
        end
    endtask

    task automatic test_reset_midflight();
        bus1.req = 2'b01;
        bus1.req_addr = {15'h0AAA, 15'h0555};
        tick();
        checks++;
        if (bus1.gnt !== 2'b01)
            $display("FAIL midflight_grant: gnt=%b want 01", bus1.gnt);
        else passes++;
        bus1.req = 2'b00;
        reset = 1'b1;
        tick();
        checks++;
        if ({bus1.gnt, bus1.rom_en, bus1.rd_valid} !== 5'b0)
            $display("FAIL midflight_in_reset: gnt/en/rdv=%b want 00000",
                     {bus1.gnt, bus1.rom_en, bus1.rd_valid});
        else passes++;
        reset = 1'b0;
        tick();
        checks++;
        if ({bus1.gnt, bus1.rom_en, bus1.rd_valid, bus1.rd_data, bus1.rom_addr} !== 26'b0)
            $display("FAIL midflight_dropped: gnt=%b en=%b rdv=%b data=%h addr=%h want all 0",
                     bus1.gnt, bus1.rom_en, bus1.rd_valid, bus1.rd_data, bus1.rom_addr);
        else passes++;
        tick();
        checks++;
        if (bus1.rd_valid !== 2'b00)
            $display("FAIL midflight_late_strobe: rdv=%b want 00", bus1.rd_valid);
        else passes++;
        bus1.req = 2'b11;
        tick();
        checks++;
        if (bus1.gnt !== 2'b01)
            $display("FAIL midflight_ptr_reset: gnt=%b want 01", bus1.gnt);
        else passes++;
        bus1.req = 2'b00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_latency();
        bus3.req = 2'b01;
        bus3.req_addr = {15'h0000, 15'h4567};
        tick();
        checks++;
        if ({bus3.gnt, bus3.rom_addr} !== {2'b01, 15'h4567})
            $display("FAIL lat3_grant: gnt=%b addr=%h want 01 4567", bus3.gnt, bus3.rom_addr);
        else passes++;
        bus3.req = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (bus3.rd_valid !== ((k == 4) ? 2'b01 : 2'b00))
                $display("FAIL lat3_strobe[%0d]: rdv=%b want %b", k, bus3.rd_valid,
                         (k == 4) ? 2'b01 : 2'b00);
            else passes++;
            if (k == 4) begin
                checks++;
                if (bus3.rd_data !== rom_word(15'h4567))
                    $display("FAIL lat3_data: data=%h want %h", bus3.rd_data, rom_word(15'h4567));
                else passes++;
            end
        end
    endtask

    initial begin
        bus1.req = '0;
        bus1.req_addr = '0;
        bus3.req = '0;
        bus3.req_addr = '0;
        test_reset();
        test_single();
        test_contention();
        test_single_hold();
        test_reset_midflight();
        test_latency();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous sprite ROM between several pixel requesters, such as the duck drawer and the gun drawer.
- Each cycle it picks at most one pending request, using round-robin, and drives the ROM address and enable.
- It tracks the in-flight read through a tag pipeline and returns the data to the requester that asked for it.
- It sits between the sprite drawers and the shared ROM, upstream of the pixel control mux and the VGA logic.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
AW, 15, ROM address width
DW, 6, ROM data width (2 bits each for R, G, B)
ROM_LAT, 1, ROM read latency in cycles, from the address-valid cycle to data-valid (1..3)

Ports:
vga_clk  in  1  pixel clock; all logic is on its rising edge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
gnt  out  NUM_REQ  one-hot grant, registered
rom_en  out  1  ROM read enable, registered
rom_addr  out  AW  ROM address, registered
rom_data  in  DW  ROM output, valid ROM_LAT cycles after rom_en
rd_valid  out  NUM_REQ  one-hot return strobe, registered
rd_data  out  DW  returned data, registered; meaningful only while rd_valid != 0

Behaviour:
- Reset (sampled high at an edge) clears gnt, rom_en, rom_addr, rd_valid, rd_data and the tag pipeline to 0, and sets the round-robin pointer to 0.
  - Reset mid-operation drops every in-flight read; no rd_valid is produced for them.
- Arbitration at edge E:
  - Consider the requesters with req=1.
  - Search starts at index ptr, wraps modulo NUM_REQ, and the first hit wins (winner w).
  - From E: gnt=onehot(w), rom_en=1, rom_addr=req_addr[w], ptr=(w+1) mod NUM_REQ.
  - If no req: gnt=0, rom_en=0, rom_addr holds its previous value, ptr unchanged.
- At most one grant per cycle. Back-to-back grants are allowed, so throughput is 1 read per cycle.
- Handshake:
  - req is level-sensitive.
  - The requester sees gnt[i] high in the cycle after edge E, and must deassert req or present its next address for the edge after that.
  - req still high at E+1 counts as a fresh request and is arbitrated again, with w now lowest priority.
  - The address is captured only at the grant edge; later changes have no effect.
- Return path:
  - A tag pipeline of depth ROM_LAT+1 carries the grant vector.
  - rd_data is rom_data registered at edge E+ROM_LAT+1.
  - rd_valid=onehot(w) is high for exactly one cycle following that edge.
  - Total latency from the grant edge to the rd_valid edge is ROM_LAT+1 cycles.
- Ordering: returns come back in grant order; there is no reordering.
- Simultaneous events: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,... with no gaps.
- Single requester: that requester gets a grant every cycle, regardless of ptr.
- rd_data holds its last value when rd_valid=0.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: pure fixed priority. The lowest index wins, ptr is unused and held at 0, and requester 0 (duck layer) can starve the others.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - the ROM width constants (AW=15, DW=6);
  - a function for the requester index from a one-hot vector;
  - the ROM_LAT default, so the ROM wrapper and the arbiter agree.
- One sub-module, rr_pick: combinational, takes req and ptr and returns onehot winner plus a valid flag. It is reused by the fixed-priority build with ptr=0.

Test Plan:
1. Reset: assert reset 2 cycles with req=2'b11 -> gnt=0, rom_en=0, rd_valid=0 throughout; the first grant after release is to requester 0.
2. Single request: req=2'b10, addr1=15'h0123 for one cycle at edge E, ROM returns 6'h2A -> gnt=2'b10 and rom_addr=0x0123 after E; rd_valid=2'b10 and rd_data=6'h2A after E+2 (ROM_LAT=1); no other strobe.
3. Contention: req=2'b11 held for 6 cycles -> gnt sequence 01,10,01,10,01,10; rd_valid follows the same sequence delayed 2 cycles; the data matches each requester's address.
4. Reset mid-flight: grant at E, reset at E+1 -> no rd_valid at E+2; all outputs are 0 at E+2.
5. Latency sweep: ROM_LAT=3, single request -> rd_valid exactly 4 cycles after the grant edge.
6. ARB_FIXED_PRIO_EN defined, req=2'b11 held for 4 cycles -> gnt=01 every cycle; requester 1 never granted until req[0] drops.
